// File: rtl/sd_cmd_tx.sv
// SD-bus command transmitter: shifts one 48-bit command frame onto the CMD
// line, one bit per tick, computing CRC7 serially. After the end bit the line
// is released for POST_BITS ticks, then done pulses and ready returns.
module sd_cmd_tx #(
  parameter int POST_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        ready,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        done
);

  localparam int GAP_W = (POST_BITS > 0) ? $clog2(POST_BITS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POST_BITS > 0) ? POST_BITS - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_DATA, S_CRC, S_END, S_GAP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [39:0]        r_shift;
  logic [6:0]         r_crc;
  logic [5:0]         r_bit_cnt;   // frame bits already driven
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_ready, r_out, r_oe, r_done;
  logic               w_ready_next, w_out_next, w_oe_next, w_done_next;
  logic               w_accept;
  logic               w_crc_fb;
  logic [6:0]         w_crc_upd;
  logic               w_payload_tick;

  // A start in the done cycle is refused so the host sees done before re-arming.
  assign w_accept       = (r_state == S_IDLE) && start && !r_done;
  assign w_crc_fb       = r_shift[39] ^ r_crc[6];
  assign w_crc_upd      = {r_crc[5:0], 1'b0} ^ {3'b000, w_crc_fb, 2'b00, w_crc_fb};
  assign w_payload_tick = tick && ((r_state == S_ARM) || (r_state == S_DATA)) &&
                          (r_bit_cnt < 6'd40);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: every transition past ARM is paced by tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_ARM;
      S_ARM:  if (tick) w_state_next = S_DATA;
      S_DATA: if (tick && r_bit_cnt == 6'd40) w_state_next = S_CRC;
      S_CRC:  if (tick && r_bit_cnt == 6'd47) w_state_next = S_END;
      S_END:  if (tick) w_state_next = (POST_BITS == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (tick && r_gap_cnt == GAP_LAST) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered line/handshake outputs.
  always_comb begin
    w_ready_next = r_ready;
    w_out_next   = r_out;
    w_oe_next    = r_oe;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_ready_next = 1'b0;
        w_oe_next    = 1'b1;
        w_out_next   = 1'b1;
      end
      S_ARM:  if (tick) w_out_next = r_shift[39];
      // Once all 40 payload bits are out, the CRC is final and its MSB follows.
      S_DATA: if (tick) w_out_next = (r_bit_cnt == 6'd40) ? r_crc[6] : r_shift[39];
      S_CRC:  if (tick) w_out_next = (r_bit_cnt == 6'd47) ? 1'b1 : r_crc[6];
      S_END:  if (tick) begin
        w_oe_next  = 1'b0;
        w_out_next = 1'b1;
        if (POST_BITS == 0) begin
          w_done_next  = 1'b1;
          w_ready_next = 1'b1;
        end
      end
      S_GAP:  if (tick && r_gap_cnt == GAP_LAST) begin
        w_done_next  = 1'b1;
        w_ready_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b1;
      r_out   <= 1'b1;
      r_oe    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= w_ready_next;
      r_out   <= w_out_next;
      r_oe    <= w_oe_next;
      r_done  <= w_done_next;
    end
  end

  // Datapath: payload shifter, serial CRC7, bit and gap counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_crc     <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= {2'b01, cmd_index, cmd_arg};
      r_crc     <= '0;
      r_bit_cnt <= '0;
    end else if (w_payload_tick) begin
      r_shift   <= {r_shift[38:0], 1'b0};
      r_crc     <= w_crc_upd;
      r_bit_cnt <= r_bit_cnt + 6'd1;
    end else if (tick && (r_state == S_DATA || r_state == S_CRC)) begin
      r_crc     <= {r_crc[5:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + 6'd1;
    end else if (tick && r_state == S_END) begin
      r_gap_cnt <= '0;
    end else if (tick && r_state == S_GAP) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  assign ready   = r_ready;
  assign cmd_out = r_out;
  assign cmd_oe  = r_oe;
  assign done    = r_done;

endmodule
